// File: rtl/mux_2to1.sv
// Two-input WIDTH-bit selector: combinational output plus a registered copy
// carrying the captured select and a saturating count of select changes.
module mux_2to1 #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             sel_q,
  output logic             valid_q,
  output logic [CNT_W-1:0] sel_changes
);

  logic [WIDTH-1:0] r_out_q;
  logic             r_sel_q;
  logic             r_valid_q;
  logic [CNT_W-1:0] r_sel_changes;

  logic [WIDTH-1:0] w_mux;
  logic             w_sel_diff;
  logic             w_cnt_max;

  // Combinational path never sees clock, reset or enable.
  assign w_mux      = sel ? b : a;
  assign out        = w_mux;
  assign w_sel_diff = (sel != r_sel_q);
  assign w_cnt_max  = &r_sel_changes;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_q       <= '0;
      r_sel_q       <= 1'b0;
      r_valid_q     <= 1'b0;
      r_sel_changes <= '0;
    end else if (en) begin
      r_out_q   <= w_mux;
      r_sel_q   <= sel;
      r_valid_q <= 1'b1;
      // Counter saturates at all-ones rather than wrapping.
      if (w_sel_diff && !w_cnt_max) begin
        r_sel_changes <= r_sel_changes + 1'b1;
      end
    end else begin
      r_valid_q <= 1'b0;
    end
  end

  assign out_q       = r_out_q;
  assign sel_q       = r_sel_q;
  assign valid_q     = r_valid_q;
  assign sel_changes = r_sel_changes;

endmodule

// File: tb/tb_mux_2to1.sv
// Directed bench for mux_2to1: a per-edge reference model pushes expected
// registered state to a scoreboard, popped and checked after each edge.
module tb_mux_2to1;

  logic       clk;
  logic       clk_run;
  logic       rst_n;
  logic [3:0] a, b;
  logic       sel, en;

  logic [3:0] out, out_q;
  logic       sel_q, valid_q;
  logic [7:0] sel_changes;

  logic [3:0] out2, out_q2;
  logic       sel_q2, valid_q2;
  logic [1:0] sel_changes2;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] oq;
    logic       sq;
    logic       vq;
    logic [7:0] c8;
    logic [1:0] c2;
  } exp_t;

  exp_t sb[$];

  logic [3:0] m_oq;
  logic       m_sq, m_vq;
  logic [7:0] m_c8;
  logic [1:0] m_c2;

  mux_2to1 #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sel(sel), .en(en),
    .out(out), .out_q(out_q), .sel_q(sel_q), .valid_q(valid_q),
    .sel_changes(sel_changes)
  );

  mux_2to1 #(.WIDTH(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sel(sel), .en(en),
    .out(out2), .out_q(out_q2), .sel_q(sel_q2), .valid_q(valid_q2),
    .sel_changes(sel_changes2)
  );

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_run) clk = ~clk;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog obs=timeout exp=finish checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] ia, input logic [3:0] ib, input logic isel,
                      input logic ien, input logic irst);
    exp_t e;
    a = ia; b = ib; sel = isel; en = ien; rst_n = irst;
    #1;
    chk("out_comb", 32'(out), 32'(isel ? ib : ia));
    if (!irst) begin
      m_oq = '0; m_sq = 1'b0; m_vq = 1'b0; m_c8 = '0; m_c2 = '0;
    end else if (ien) begin
      if (isel != m_sq) begin
        if (m_c8 != 8'hFF) m_c8 = m_c8 + 8'd1;
        if (m_c2 != 2'd3)  m_c2 = m_c2 + 2'd1;
      end
      m_oq = isel ? ib : ia;
      m_sq = isel;
      m_vq = 1'b1;
    end else begin
      m_vq = 1'b0;
    end
    e.oq = m_oq; e.sq = m_sq; e.vq = m_vq; e.c8 = m_c8; e.c2 = m_c2;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("out_q",         32'(out_q),        32'(e.oq));
      chk("sel_q",         32'(sel_q),        32'(e.sq));
      chk("valid_q",       32'(valid_q),      32'(e.vq));
      chk("sel_changes",   32'(sel_changes),  32'(e.c8));
      chk("sel_changes_2", 32'(sel_changes2), 32'(e.c2));
      chk("out_q_2",       32'(out_q2),       32'(e.oq));
    end
  endtask

  initial begin
    clk_run = 1'b0;
    rst_n = 1'b0; en = 1'b0;
    m_oq = '0; m_sq = 1'b0; m_vq = 1'b0; m_c8 = '0; m_c2 = '0;

    // Combinational path with the clock stopped.
    a = 4'b0000; b = 4'b1111; sel = 1'b0;
    #10 chk("comb_sel0", 32'(out), 32'd0);
    sel = 1'b1;
    #10 chk("comb_sel1", 32'(out), 32'd15);
    a = 4'h9; sel = 1'b0;
    #1 chk("comb_zero_delay", 32'(out), 32'h9);

    clk_run = 1'b1;

    // Reset held two edges with en=1, sel=1.
    step(4'h0, 4'hF, 1'b1, 1'b1, 1'b0);
    step(4'h0, 4'hF, 1'b1, 1'b1, 1'b0);

    // Continuous capture, sel toggling 0,1,0,1.
    step(4'd3, 4'd12, 1'b0, 1'b1, 1'b1);
    step(4'd3, 4'd12, 1'b1, 1'b1, 1'b1);
    step(4'd3, 4'd12, 1'b0, 1'b1, 1'b1);
    step(4'd3, 4'd12, 1'b1, 1'b1, 1'b1);
    chk("cnt_after_toggle", 32'(sel_changes), 32'd3);

    // Hold: inputs move, registered state must not.
    step(4'd5, 4'd6, 1'b0, 1'b0, 1'b1);
    step(4'd7, 4'd1, 1'b1, 1'b0, 1'b1);
    step(4'd2, 4'd8, 1'b0, 1'b0, 1'b1);

    // Six toggling captures: 2-bit counter pins at 3, 8-bit keeps counting.
    for (int i = 0; i < 6; i++) begin
      step(4'(i), 4'(15 - i), logic'(i[0]), 1'b1, 1'b1);
    end
    chk("sat_cnt2", 32'(sel_changes2), 32'd3);

    // Simultaneous data and sel change at a capture edge.
    step(4'hA, 4'h5, 1'b0, 1'b1, 1'b1);
    step(4'hC, 4'h3, 1'b1, 1'b1, 1'b1);

    // Reset with a capture due and sel changing: reset wins.
    step(4'hE, 4'h4, 1'b0, 1'b1, 1'b0);
    chk("rst_mid_cnt", 32'(sel_changes), 32'd0);

    // First capture after reset with sel=1 counts as a change.
    step(4'h1, 4'hB, 1'b1, 1'b1, 1'b1);
    step(4'h1, 4'hB, 1'b1, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_2to1.md
Name: mux_2to1

Overview:
- Two-input, WIDTH-bit selector with a combinational output and a registered copy.
- Combinational path: out = sel ? b : a, valid immediately and never affected by clock or reset.
- Registered stage captures the selected word, the select value, and a saturating count of select changes for downstream timing-closed consumers.
- Used as a generic datapath steering element.

Parameters:
- WIDTH, 4, data width of a, b, out, out_q.
- CNT_W, 8, width of the select-change counter.

Ports:
- clk  input  1  rising-edge clock for the registered stage.
- rst_n  input  1  synchronous, active-low reset.
- a  input  WIDTH  data word selected when sel=0.
- b  input  WIDTH  data word selected when sel=1.
- sel  input  1  select: 0 -> a, 1 -> b.
- en  input  1  capture enable for the registered stage.
- out  output  WIDTH  combinational mux result.
- out_q  output  WIDTH  registered mux result.
- sel_q  output  1  select value at last capture.
- valid_q  output  1  one-cycle pulse, high the cycle after a capture.
- sel_changes  output  CNT_W  count of captures whose sel differed from sel_q; saturates.

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- out = (sel == 1) ? b : a, purely combinational.
  - No latency; updates within the same delta as any input change.
  - Unaffected by rst_n and en.
  - X/Z on sel: out follows standard conditional-operator semantics. No special handling is required.
- All other outputs update only on the rising edge of clk.
- Reset (rst_n == 0 at a rising edge):
  - out_q = 0, sel_q = 0, valid_q = 0, sel_changes = 0.
  - Reset has priority over en.
  - Reset mid-operation discards any capture due that cycle.
- Capture (rst_n == 1 and en == 1 at a rising edge):
  - out_q <= (sel ? b : a); sel_q <= sel; valid_q <= 1.
  - If sel != sel_q, sel_changes increments by 1, saturating at 2^CNT_W - 1 (never wraps).
  - The first capture after reset with sel=1 counts as a change, because sel_q resets to 0.
- Hold (rst_n == 1 and en == 0 at a rising edge):
  - out_q, sel_q and sel_changes hold; valid_q <= 0.
- Continuous capture (en held high) gives valid_q high on every cycle. There is exactly one cycle of latency from inputs to out_q.
- Simultaneous change of sel and data at a capturing edge: the values sampled at that edge are used, both for out_q and for the change comparison.

Test Plan:
- a=4'b0000, b=4'b1111, sel=0, wait 10ns -> out=0; then sel=1, wait 10ns -> out=15. Combinational only; clock and reset idle.
- Reset: rst_n=0 for 2 cycles with en=1 and sel=1 -> out_q=0, sel_q=0, valid_q=0, sel_changes=0. out still tracks b combinationally.
- After reset, en=1, a=3, b=12, sel toggling 0,1,0,1 on successive edges:
  - out_q = 3, 12, 3, 12 (each one cycle after its inputs).
  - valid_q high each cycle.
  - sel_changes ends at 3.
- en=0 while a, b and sel change -> out_q and sel_changes hold, valid_q=0, out follows the inputs.
- Saturation: CNT_W=2, sel toggled on 6 consecutive captures -> sel_changes stops at 3.
- rst_n asserted in the same cycle as en=1 with sel changing -> all registered outputs read 0 at the next edge; no count increment.
